// File: rtl/core_id_scoreboard_pkg.sv
// Shared constants for the ID-stage issue scoreboard: default geometry and drain FSM encodings.
package core_id_scoreboard_pkg;

    localparam int CORE_SB_RFIDX_W         = 5;
    localparam int CORE_SB_CNT_WIDTH       = 2;
    localparam int CORE_SB_MAX_OUTSTANDING = 4;

    localparam logic [1:0] SB_IDLE  = 2'd0;
    localparam logic [1:0] SB_DRAIN = 2'd1;
    localparam logic [1:0] SB_DONE  = 2'd2;

    function automatic int sb_out_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/core_id_scoreboard_if.sv
// Issue/writeback/drain bundle between the ID stage (master) and the scoreboard (slave).
interface core_id_scoreboard_if
    import core_id_scoreboard_pkg::*;
#(
    parameter int RFIDX_W         = CORE_SB_RFIDX_W,
    parameter int MAX_OUTSTANDING = CORE_SB_MAX_OUTSTANDING
);
    localparam int NREGS = 1 << RFIDX_W;
    localparam int OUT_W = sb_out_width(MAX_OUTSTANDING);

    logic               issue_valid;
    logic               issue_ready;
    logic               rs1_ren;
    logic [RFIDX_W-1:0] rs1_idx;
    logic               rs2_ren;
    logic [RFIDX_W-1:0] rs2_idx;
    logic               rd_wen;
    logic [RFIDX_W-1:0] rd_idx;
    logic               long_lat;
    logic               wb_valid;
    logic [RFIDX_W-1:0] wb_idx;
    logic               pipe_flush_req;
    logic               drain_req;
    logic               stall;
    logic               drain_done;
    logic [OUT_W-1:0]   outstanding;
    logic [NREGS-1:0]   busy_vec;

    modport master (
        output issue_valid, issue_ready, rs1_ren, rs1_idx, rs2_ren, rs2_idx,
               rd_wen, rd_idx, long_lat, wb_valid, wb_idx, pipe_flush_req, drain_req,
        input  stall, drain_done, outstanding, busy_vec
    );

    modport slave (
        input  issue_valid, issue_ready, rs1_ren, rs1_idx, rs2_ren, rs2_idx,
               rd_wen, rd_idx, long_lat, wb_valid, wb_idx, pipe_flush_req, drain_req,
        output stall, drain_done, outstanding, busy_vec
    );

endinterface

// File: rtl/core_sb_cnt.sv
// One register's in-flight write counter: saturating up/down, decrement of zero ignored.
module core_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic dec_ok;

    assign dec_ok = dec && (cnt != '0);
    assign busy   = (cnt != '0);

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    // NOTE: every counter is reset; a stale nonzero count out of reset would block issue forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec_ok && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec_ok && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_id_scoreboard.sv
// Issue-side hazard scheduler: tracks long-latency destinations, gates issue on RAW/WAW/capacity,
// sequences fence/ebreak drains. Optional macro CORE_SB_WB_BYPASS_EN lets a final writeback clear busy same-cycle.
module core_id_scoreboard
    import core_id_scoreboard_pkg::*;
#(
    parameter int RFIDX_W         = CORE_SB_RFIDX_W,
    parameter int CNT_W           = CORE_SB_CNT_WIDTH,
    parameter int MAX_OUTSTANDING = CORE_SB_MAX_OUTSTANDING
) (
    input logic                 clk,
    input logic                 rst,
    core_id_scoreboard_if.slave sb
);

    localparam int NREGS = 1 << RFIDX_W;
    localparam int OUT_W = sb_out_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREGS-1:0][CNT_W-1:0] cnt;
    logic [NREGS-1:0]            busy_reg;
    logic [NREGS-1:0]            busy_now;
    logic [CNT_W-1:0]            wb_cnt;
    logic [CNT_W-1:0]            rd_cnt;
    logic [OUT_W-1:0]            outstanding;
    logic [OUT_W-1:0]            out_eff;
    logic [1:0]                  state;
    logic [1:0]                  state_nxt;
    logic                        raw, waw, full, stall;
    logic                        fire, track, clr;

    // x0 is hardwired zero and never tracked.
    assign cnt[0]      = '0;
    assign busy_reg[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        core_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (track && (sb.rd_idx == RFIDX_W'(r))),
            .dec  (sb.wb_valid && (sb.wb_idx == RFIDX_W'(r))),
            .cnt  (cnt[r]),
            .busy (busy_reg[r])
        );
    end

    assign wb_cnt = cnt[sb.wb_idx];
    assign rd_cnt = cnt[sb.rd_idx];
    assign clr    = sb.wb_valid && (wb_cnt != '0);

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        busy_now = busy_reg;
        out_eff  = outstanding;
`ifdef CORE_SB_WB_BYPASS_EN
        if (sb.wb_valid && (wb_cnt == CNT_W'(1))) begin
            busy_now[sb.wb_idx] = 1'b0;
        end
        out_eff = outstanding - OUT_W'(clr);
`endif
    end

    assign raw  = (sb.rs1_ren && (sb.rs1_idx != '0) && busy_now[sb.rs1_idx]) ||
                  (sb.rs2_ren && (sb.rs2_idx != '0) && busy_now[sb.rs2_idx]);
    assign waw  = sb.rd_wen && sb.long_lat && (sb.rd_idx != '0) && (rd_cnt == CNT_MAX);
    assign full = sb.long_lat && (out_eff == OUT_W'(MAX_OUTSTANDING));

    // issue_ready is deliberately absent here to avoid a loop with the EXU's ready logic.
    assign stall = (state != SB_IDLE) || raw || waw || full;
    assign fire  = sb.issue_valid && sb.issue_ready && !stall && !sb.pipe_flush_req;
    assign track = fire && sb.long_lat && sb.rd_wen && (sb.rd_idx != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(track) - OUT_W'(clr);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SB_IDLE:  if (sb.drain_req) state_nxt = SB_DRAIN;
            SB_DRAIN: if (outstanding == '0) state_nxt = SB_DONE;
            SB_DONE:  state_nxt = SB_IDLE;
            default:  state_nxt = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A writeback with no matching in-flight op indicates an upstream bookkeeping bug.
    always_ff @(posedge clk) begin
        if (!rst && sb.wb_valid) begin
            assert (wb_cnt != '0);
        end
    end

    assign sb.stall       = stall;
    assign sb.drain_done  = (state == SB_DONE);
    assign sb.outstanding = outstanding;
    assign sb.busy_vec    = busy_reg;

endmodule

// File: tb/tb_core_id_scoreboard.sv
// Self-checking bench for core_id_scoreboard: directed scenarios plus randomized traffic vs a count-based model.
module tb_core_id_scoreboard;

`ifdef CORE_SB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int NR        = 32;
    localparam int CNT_LIMIT = 3;
    localparam int MAXO      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    core_id_scoreboard_if #(.RFIDX_W(5), .MAX_OUTSTANDING(MAXO)) sb ();

    core_id_scoreboard #(.RFIDX_W(5), .CNT_W(2), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight writes per register, total in flight, drain phase (0 idle, 1 draining, 2 done).
    int          mcnt [NR];
    int          mout;
    int          phase;
    bit          e_stall;
    int          e_out;
    bit          e_done;
    logic [31:0] e_busy;
    int          n_checks;
    int          n_fail;

    task automatic idle();
        sb.issue_valid    = 1'b0;
        sb.issue_ready    = 1'b1;
        sb.rs1_ren        = 1'b0;
        sb.rs1_idx        = '0;
        sb.rs2_ren        = 1'b0;
        sb.rs2_idx        = '0;
        sb.rd_wen         = 1'b0;
        sb.rd_idx         = '0;
        sb.long_lat       = 1'b0;
        sb.wb_valid       = 1'b0;
        sb.wb_idx         = '0;
        sb.pipe_flush_req = 1'b0;
        sb.drain_req      = 1'b0;
    endtask

    task automatic set_op(input bit lng, input int rd, input bit r1en, input int r1, input bit r2en, input int r2);
        sb.issue_valid = 1'b1;
        sb.long_lat    = lng;
        sb.rd_wen      = 1'b1;
        sb.rd_idx      = 5'(rd);
        sb.rs1_ren     = r1en;
        sb.rs1_idx     = 5'(r1);
        sb.rs2_ren     = r2en;
        sb.rs2_idx     = 5'(r2);
    endtask

    task automatic set_wb(input int idx);
        sb.wb_valid = 1'b1;
        sb.wb_idx   = 5'(idx);
    endtask

    function automatic bit m_busy(input logic [4:0] idx);
        if (idx == 0 || mcnt[idx] == 0) return 1'b0;
        if (BYPASS && sb.wb_valid && sb.wb_idx == idx && mcnt[idx] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic predict();
        bit clr_now;
        int out_eff;
        #1;
        clr_now = sb.wb_valid && (mcnt[sb.wb_idx] != 0);
        out_eff = BYPASS ? mout - int'(clr_now) : mout;
        e_stall = (phase != 0)
               || (sb.rs1_ren && m_busy(sb.rs1_idx))
               || (sb.rs2_ren && m_busy(sb.rs2_idx))
               || (sb.rd_wen && sb.long_lat && sb.rd_idx != 0 && mcnt[sb.rd_idx] == CNT_LIMIT)
               || (sb.long_lat && out_eff == MAXO);
        e_out  = mout;
        e_done = (phase == 2);
        for (int r = 0; r < NR; r++) e_busy[r] = (mcnt[r] != 0);
    endtask

    task automatic tick();
        bit fire_m, trk, clr_m;
        int rd, wbi, nph;
        fire_m = sb.issue_valid && sb.issue_ready && !e_stall && !sb.pipe_flush_req;
        trk    = fire_m && sb.long_lat && sb.rd_wen && sb.rd_idx != 0;
        clr_m  = sb.wb_valid && mcnt[sb.wb_idx] != 0;
        rd     = sb.rd_idx;
        wbi    = sb.wb_idx;
        nph    = phase;
        case (phase)
            0:       if (sb.drain_req) nph = 1;
            1:       if (mout == 0) nph = 2;
            default: nph = 0;
        endcase
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < NR; r++) mcnt[r] = 0;
            mout  = 0;
            phase = 0;
        end else begin
            mcnt[rd]  += int'(trk);
            mcnt[wbi] -= int'(clr_m);
            mout      += int'(trk) - int'(clr_m);
            phase      = nph;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        sb.drain_req = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();
        predict();
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b exp 0", sb.stall); end
        n_checks++; if (sb.outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d exp 0", sb.outstanding); end
        n_checks++; if (sb.busy_vec !== 32'd0) begin n_fail++; $display("FAIL reset_busy_vec: got %h exp 0", sb.busy_vec); end
        n_checks++; if (sb.drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_drain_done: got %0b exp 0", sb.drain_done); end
        tick();
    endtask

    task automatic test_raw();
        int issued_at = -1;
        int exp_at    = BYPASS ? 3 : 4;
        idle(); set_op(1, 5, 0, 0, 0, 0); predict();
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL raw_load_issue: got stall %0b exp 0", sb.stall); end
        tick();
        for (int c = 0; c < 8; c++) begin
            idle(); set_op(0, 10, 1, 5, 0, 0);
            if (c == 3) set_wb(5);
            predict();
            n_checks++; if (sb.stall !== e_stall) begin n_fail++; $display("FAIL raw_stall c%0d: got %0b exp %0b", c, sb.stall, e_stall); end
            if (sb.stall === 1'b0 && issued_at < 0) issued_at = c;
            tick();
            if (issued_at >= 0) break;
        end
        n_checks++; if (issued_at != exp_at) begin n_fail++; $display("FAIL raw_issue_cycle: got %0d exp %0d", issued_at, exp_at); end
        idle(); predict();
        n_checks++; if (sb.outstanding !== 3'd0 || sb.busy_vec !== 32'd0) begin n_fail++; $display("FAIL raw_cleanup: got out %0d busy %h exp 0/0", sb.outstanding, sb.busy_vec); end
        tick();
    endtask

    task automatic test_x0();
        idle(); set_op(1, 0, 0, 0, 0, 0); predict();
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL x0_load_stall: got %0b exp 0", sb.stall); end
        tick();
        idle(); set_op(0, 3, 1, 0, 1, 0); predict();
        n_checks++; if (sb.outstanding !== 3'd0) begin n_fail++; $display("FAIL x0_outstanding: got %0d exp 0", sb.outstanding); end
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL x0_reader_stall: got %0b exp 0", sb.stall); end
        tick();
    endtask

    task automatic test_flush();
        idle(); set_op(1, 11, 0, 0, 0, 0); sb.pipe_flush_req = 1'b1; predict();
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b exp 0", sb.stall); end
        tick();
        idle(); predict();
        n_checks++; if (sb.outstanding !== 3'd0 || sb.busy_vec !== 32'd0) begin n_fail++; $display("FAIL flush_untracked: got out %0d busy %h exp 0/0", sb.outstanding, sb.busy_vec); end
        tick();
    endtask

    task automatic test_capacity();
        for (int r = 1; r <= 4; r++) begin
            idle(); set_op(1, r, 0, 0, 0, 0); predict();
            n_checks++; if (sb.stall !== e_stall) begin n_fail++; $display("FAIL cap_issue x%0d: got %0b exp %0b", r, sb.stall, e_stall); end
            tick();
        end
        idle(); set_op(1, 8, 0, 0, 0, 0); predict();
        n_checks++; if (sb.outstanding !== 3'd4) begin n_fail++; $display("FAIL cap_outstanding: got %0d exp 4", sb.outstanding); end
        n_checks++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL cap_fifth_long: got %0b exp 1", sb.stall); end
        tick();
        idle(); set_op(0, 9, 1, 10, 0, 0); predict();
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL cap_short_op: got %0b exp 0", sb.stall); end
        tick();
        for (int r = 1; r <= 4; r++) begin
            idle(); set_wb(r); predict(); tick();
        end
        idle(); predict();
        n_checks++; if (sb.outstanding !== 3'd0) begin n_fail++; $display("FAIL cap_drained: got %0d exp 0", sb.outstanding); end
        tick();
    endtask

    task automatic test_waw();
        for (int k = 0; k < 3; k++) begin
            idle(); set_op(1, 7, 0, 0, 0, 0); predict(); tick();
        end
        idle(); set_op(1, 7, 0, 0, 0, 0); predict();
        n_checks++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL waw_sat_stall: got %0b exp 1", sb.stall); end
        n_checks++; if (sb.busy_vec !== 32'h80 || sb.outstanding !== 3'd3) begin n_fail++; $display("FAIL waw_state: got busy %h out %0d exp 80/3", sb.busy_vec, sb.outstanding); end
        tick();
        idle(); set_op(1, 7, 0, 0, 0, 0); set_wb(7); predict();
        n_checks++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL waw_wb_cycle: got %0b exp 1", sb.stall); end
        tick();
        idle(); set_op(1, 7, 0, 0, 0, 0); predict();
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL waw_after_wb: got %0b exp 0", sb.stall); end
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(); set_wb(7); predict(); tick();
        end
        idle(); predict();
        n_checks++; if (sb.outstanding !== 3'd0) begin n_fail++; $display("FAIL waw_drained: got %0d exp 0", sb.outstanding); end
        tick();
    endtask

    task automatic test_same_cycle();
        idle(); set_op(1, 6, 0, 0, 0, 0); predict(); tick();
        idle(); set_op(1, 6, 0, 0, 0, 0); set_wb(6); predict();
        n_checks++; if (sb.stall !== 1'b0) begin n_fail++; $display("FAIL same_stall: got %0b exp 0", sb.stall); end
        tick();
        idle(); set_wb(6); predict();
        n_checks++; if (sb.outstanding !== 3'd1 || sb.busy_vec !== 32'h40) begin n_fail++; $display("FAIL same_track_wb: got out %0d busy %h exp 1/40", sb.outstanding, sb.busy_vec); end
        tick();
        idle(); predict();
        n_checks++; if (sb.outstanding !== 3'd0) begin n_fail++; $display("FAIL same_final_wb: got %0d exp 0", sb.outstanding); end
        tick();
    endtask

    task automatic test_drain();
        int done_cnt = 0;
        idle(); set_op(1, 2, 0, 0, 0, 0); predict(); tick();
        idle(); set_op(1, 3, 0, 0, 0, 0); predict(); tick();
        idle(); sb.drain_req = 1'b1; predict(); tick();
        idle(); set_op(0, 9, 0, 0, 0, 0); predict();
        n_checks++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL drain_stall: got %0b exp 1", sb.stall); end
        tick();
        idle(); set_op(0, 9, 0, 0, 0, 0); set_wb(2); predict(); tick();
        idle(); set_op(0, 9, 0, 0, 0, 0); set_wb(3); predict(); tick();
        for (int c = 0; c < 8; c++) begin
            idle(); set_op(0, 9, 0, 0, 0, 0); predict();
            n_checks++; if (sb.stall !== e_stall || sb.drain_done !== e_done) begin n_fail++; $display("FAIL drain_seq c%0d: got stall %0b done %0b exp %0b %0b", c, sb.stall, sb.drain_done, e_stall, e_done); end
            if (sb.drain_done === 1'b1) done_cnt++;
            tick();
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL drain_pulse_count: got %0d exp 1", done_cnt); end
        // Drain with nothing in flight: done visible two edges after the request.
        idle(); sb.drain_req = 1'b1; predict(); tick();
        idle(); predict();
        n_checks++; if (sb.drain_done !== 1'b0) begin n_fail++; $display("FAIL drain0_early: got %0b exp 0", sb.drain_done); end
        tick();
        idle(); predict();
        n_checks++; if (sb.drain_done !== 1'b1) begin n_fail++; $display("FAIL drain0_done: got %0b exp 1", sb.drain_done); end
        tick();
        idle(); predict();
        n_checks++; if (sb.drain_done !== 1'b0 || sb.stall !== 1'b0) begin n_fail++; $display("FAIL drain0_idle: got done %0b stall %0b exp 0/0", sb.drain_done, sb.stall); end
        tick();
        // Reset while draining: back to idle, no done pulse.
        idle(); set_op(1, 4, 0, 0, 0, 0); predict(); tick();
        idle(); sb.drain_req = 1'b1; predict(); tick();
        idle(); predict();
        n_checks++; if (sb.stall !== 1'b1) begin n_fail++; $display("FAIL rstdrain_in_drain: got %0b exp 1", sb.stall); end
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            idle(); predict();
            n_checks++; if (sb.drain_done !== 1'b0 || sb.stall !== 1'b0 || sb.outstanding !== 3'd0) begin n_fail++; $display("FAIL rstdrain_idle c%0d: got done %0b stall %0b out %0d exp 0/0/0", c, sb.drain_done, sb.stall, sb.outstanding); end
            tick();
        end
    endtask

    task automatic test_random();
        int busy_list [$];
        for (int i = 0; i < 600; i++) begin
            idle();
            sb.issue_valid    = ($urandom_range(0, 3) != 0);
            sb.issue_ready    = ($urandom_range(0, 3) != 0);
            sb.rs1_ren        = $urandom_range(0, 1) == 1;
            sb.rs1_idx        = 5'($urandom_range(0, 7));
            sb.rs2_ren        = $urandom_range(0, 1) == 1;
            sb.rs2_idx        = 5'($urandom_range(0, 7));
            sb.rd_wen         = ($urandom_range(0, 3) != 0);
            sb.rd_idx         = 5'($urandom_range(0, 7));
            sb.long_lat       = $urandom_range(0, 1) == 1;
            sb.pipe_flush_req = ($urandom_range(0, 7) == 0);
            sb.drain_req      = ($urandom_range(0, 15) == 0);
            if (mout > 0 && $urandom_range(0, 1) == 1) begin
                busy_list.delete();
                for (int r = 1; r < NR; r++) if (mcnt[r] != 0) busy_list.push_back(r);
                set_wb(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            end
            predict();
            n_checks++; if (sb.stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall i%0d: got %0b exp %0b", i, sb.stall, e_stall); end
            n_checks++; if (sb.outstanding !== 3'(e_out)) begin n_fail++; $display("FAIL rnd_outstanding i%0d: got %0d exp %0d", i, sb.outstanding, e_out); end
            n_checks++; if (sb.busy_vec !== e_busy) begin n_fail++; $display("FAIL rnd_busy_vec i%0d: got %h exp %h", i, sb.busy_vec, e_busy); end
            n_checks++; if (sb.drain_done !== e_done) begin n_fail++; $display("FAIL rnd_drain_done i%0d: got %0b exp %0b", i, sb.drain_done, e_done); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mout     = 0;
        phase    = 0;
        e_stall  = 1'b0;
        for (int r = 0; r < NR; r++) mcnt[r] = 0;
        idle();
        test_reset();
        test_raw();
        test_x0();
        test_flush();
        test_capacity();
        test_waw();
        test_same_cycle();
        test_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
